// File: rtl/ex_issue_stage.sv
// rtl/ex_issue_stage.sv - ID/EX issue register with ALU control decode and operand forwarding
// Define EX_FWD_EN to build the EX/MEM and MEM/WB forwarding muxes; otherwise operands come straight from the register file.
module ex_issue_stage #(
   parameter int XLEN = 32,
   parameter int RAW  = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_rs1_data,
   input  logic [XLEN-1:0] in_rs2_data,
   input  logic [XLEN-1:0] in_imm,
   input  logic [RAW-1:0]  in_rs1_addr,
   input  logic [RAW-1:0]  in_rs2_addr,
   input  logic [RAW-1:0]  in_rd_addr,
   input  logic [1:0]      in_alu_op,
   input  logic [5:0]      in_funct,
   input  logic            in_alu_src,
   input  logic            in_reg_write,
   input  logic            ex_mem_reg_write,
   input  logic [RAW-1:0]  ex_mem_rd,
   input  logic [XLEN-1:0] ex_mem_result,
   input  logic            mem_wb_reg_write,
   input  logic [RAW-1:0]  mem_wb_rd,
   input  logic [XLEN-1:0] mem_wb_result,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic [3:0]      alu_ctrl,
   output logic [XLEN-1:0] out_store_data,
   output logic [RAW-1:0]  out_rd_addr,
   output logic            out_reg_write,
   output logic            illegal_op
);

   localparam logic [3:0] CTRL_AND = 4'b0000;
   localparam logic [3:0] CTRL_OR  = 4'b0001;
   localparam logic [3:0] CTRL_ADD = 4'b0010;
   localparam logic [3:0] CTRL_SUB = 4'b0110;
   localparam logic [3:0] CTRL_NOR = 4'b1100;
   localparam logic [3:0] CTRL_BAD = 4'b1111;

   logic            valid_q, valid_d;
   logic [XLEN-1:0] rs1_data_q, rs1_data_d;
   logic [XLEN-1:0] rs2_data_q, rs2_data_d;
   logic [XLEN-1:0] imm_q, imm_d;
   logic [RAW-1:0]  rs1_addr_q, rs1_addr_d;
   logic [RAW-1:0]  rs2_addr_q, rs2_addr_d;
   logic [RAW-1:0]  rd_addr_q, rd_addr_d;
   logic [3:0]      alu_ctrl_q, alu_ctrl_d;
   logic            alu_src_q, alu_src_d;
   logic            reg_write_q, reg_write_d;
   logic            illegal_q, illegal_d;

   logic            capture;
   logic [3:0]      dec_ctrl;
   logic            dec_illegal;
   logic [XLEN-1:0] fwd_a;
   logic [XLEN-1:0] fwd_b;

   assign in_ready = !valid_q || out_ready;
   assign capture  = in_valid && in_ready && !flush;

   always_comb begin
      dec_ctrl    = CTRL_BAD;
      dec_illegal = 1'b0;
      case (in_alu_op)
         2'b00: dec_ctrl = CTRL_ADD;
         2'b01: dec_ctrl = CTRL_SUB;
         2'b10: begin
            case (in_funct)
               6'b100000: dec_ctrl = CTRL_ADD;
               6'b100010: dec_ctrl = CTRL_SUB;
               6'b100100: dec_ctrl = CTRL_AND;
               6'b100101: dec_ctrl = CTRL_OR;
               6'b100111: dec_ctrl = CTRL_NOR;
               default:   dec_illegal = 1'b1;
            endcase
         end
         default: dec_illegal = 1'b1;
      endcase
   end

   // Payload only moves on capture; a flush clears valid/illegal but leaves the data stale.
   always_comb begin
      valid_d     = valid_q;
      rs1_data_d  = rs1_data_q;
      rs2_data_d  = rs2_data_q;
      imm_d       = imm_q;
      rs1_addr_d  = rs1_addr_q;
      rs2_addr_d  = rs2_addr_q;
      rd_addr_d   = rd_addr_q;
      alu_ctrl_d  = alu_ctrl_q;
      alu_src_d   = alu_src_q;
      reg_write_d = reg_write_q;
      illegal_d   = illegal_q;
      if (flush) begin
         valid_d   = 1'b0;
         illegal_d = 1'b0;
      end else if (capture) begin
         valid_d     = 1'b1;
         rs1_data_d  = in_rs1_data;
         rs2_data_d  = in_rs2_data;
         imm_d       = in_imm;
         rs1_addr_d  = in_rs1_addr;
         rs2_addr_d  = in_rs2_addr;
         rd_addr_d   = in_rd_addr;
         alu_ctrl_d  = dec_ctrl;
         alu_src_d   = in_alu_src;
         reg_write_d = in_reg_write;
         illegal_d   = dec_illegal;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q     <= 1'b0;
         rs1_data_q  <= '0;
         rs2_data_q  <= '0;
         imm_q       <= '0;
         rs1_addr_q  <= '0;
         rs2_addr_q  <= '0;
         rd_addr_q   <= '0;
         alu_ctrl_q  <= 4'b0000;
         alu_src_q   <= 1'b0;
         reg_write_q <= 1'b0;
         illegal_q   <= 1'b0;
      end else begin
         valid_q     <= valid_d;
         rs1_data_q  <= rs1_data_d;
         rs2_data_q  <= rs2_data_d;
         imm_q       <= imm_d;
         rs1_addr_q  <= rs1_addr_d;
         rs2_addr_q  <= rs2_addr_d;
         rd_addr_q   <= rd_addr_d;
         alu_ctrl_q  <= alu_ctrl_d;
         alu_src_q   <= alu_src_d;
         reg_write_q <= reg_write_d;
         illegal_q   <= illegal_d;
      end
   end

`ifdef EX_FWD_EN
   // EX/MEM is assigned last so it overrides MEM/WB; x0 is hard-wired and never forwarded.
   always_comb begin
      fwd_a = rs1_data_q;
      fwd_b = rs2_data_q;
      if (mem_wb_reg_write && mem_wb_rd == rs1_addr_q && rs1_addr_q != '0) fwd_a = mem_wb_result;
      if (ex_mem_reg_write && ex_mem_rd == rs1_addr_q && rs1_addr_q != '0) fwd_a = ex_mem_result;
      if (mem_wb_reg_write && mem_wb_rd == rs2_addr_q && rs2_addr_q != '0) fwd_b = mem_wb_result;
      if (ex_mem_reg_write && ex_mem_rd == rs2_addr_q && rs2_addr_q != '0) fwd_b = ex_mem_result;
   end
`else
   logic unused_fwd;
   assign unused_fwd = ^{ex_mem_reg_write, ex_mem_rd, ex_mem_result,
                         mem_wb_reg_write, mem_wb_rd, mem_wb_result,
                         rs1_addr_q, rs2_addr_q};
   assign fwd_a = rs1_data_q;
   assign fwd_b = rs2_data_q;
`endif

   assign out_valid      = valid_q;
   assign alu_a          = fwd_a;
   assign alu_b          = alu_src_q ? imm_q : fwd_b;
   assign alu_ctrl       = alu_ctrl_q;
   assign out_store_data = fwd_b;
   assign out_rd_addr    = rd_addr_q;
   assign out_reg_write  = valid_q && reg_write_q && !illegal_q;
   assign illegal_op     = illegal_q;

endmodule
